// File: rtl/fp_mul_arb_pkg.sv
// Shared types and widths for the fp_mul_arbiter slice.
package fp_mul_arb_pkg;

    localparam int unsigned FP_WIDTH   = 32;
    localparam int unsigned OP_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Request/response bundle between client engines and fp_mul_arbiter.
// out_op_count exists only when FP_MUL_ARB_STATS_EN is defined.
interface fp_mul_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import fp_mul_arb_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          in_req_valid;
    logic [NUM_REQ-1:0]          out_req_ready;
    logic [NUM_REQ*FP_WIDTH-1:0] in_req_numA;
    logic [NUM_REQ*FP_WIDTH-1:0] in_req_numB;
    logic                        out_rsp_valid;
    logic                        in_rsp_ready;
    logic [ID_W-1:0]             out_rsp_id;
    logic [FP_WIDTH-1:0]         out_rsp_result;
`ifdef FP_MUL_ARB_STATS_EN
    logic [OP_COUNT_W-1:0]       out_op_count;
`endif

    modport master (
        output in_req_valid,
        output in_req_numA,
        output in_req_numB,
        output in_rsp_ready,
        input  out_req_ready,
        input  out_rsp_valid,
        input  out_rsp_id,
`ifdef FP_MUL_ARB_STATS_EN
        input  out_op_count,
`endif
        input  out_rsp_result
    );

    modport slave (
        input  in_req_valid,
        input  in_req_numA,
        input  in_req_numB,
        input  in_rsp_ready,
        output out_req_ready,
        output out_rsp_valid,
        output out_rsp_id,
`ifdef FP_MUL_ARB_STATS_EN
        output out_op_count,
`endif
        output out_rsp_result
    );

endinterface

// File: rtl/FP_Mul.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Denormal inputs/results flush to signed zero; every NaN becomes the canonical quiet NaN.
module FP_Mul
    import fp_mul_arb_pkg::*;
(
    input  logic [FP_WIDTH-1:0] in_numA,
    input  logic [FP_WIDTH-1:0] in_numB,
    output logic [FP_WIDTH-1:0] out_result
);

    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [23:0] sig;
    logic        guard, sticky, rnd;
    logic [24:0] sig_r;
    logic [9:0]  exp_s;

    assign sign   = in_numA[31] ^ in_numB[31];
    assign ea     = in_numA[30:23];
    assign eb     = in_numB[30:23];
    assign ma     = in_numA[22:0];
    assign mb     = in_numB[22:0];
    assign a_nan  = (ea == 8'hFF) && (ma != '0);
    assign b_nan  = (eb == 8'hFF) && (mb != '0);
    assign a_inf  = (ea == 8'hFF) && (ma == '0);
    assign b_inf  = (eb == 8'hFF) && (mb == '0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        prod = 48'({1'b1, ma}) * 48'({1'b1, mb});
        if (prod[47]) begin
            sig    = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_s  = 10'(ea) + 10'(eb) - 10'd126;
        end else begin
            sig    = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_s  = 10'(ea) + 10'(eb) - 10'd127;
        end
        rnd   = guard & (sticky | sig[0]);
        sig_r = {1'b0, sig} + 25'(rnd);
        // rounding carry out leaves an all-zero fraction one exponent higher
        if (sig_r[24]) begin
            exp_s = exp_s + 10'd1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            out_result = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            out_result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            out_result = {sign, 31'd0};
        end else if ($signed(exp_s) >= 10'sd255) begin
            out_result = {sign, 8'hFF, 23'd0};
        end else if ($signed(exp_s) <= 10'sd0) begin
            out_result = {sign, 31'd0};
        end else begin
            out_result = {sign, exp_s[7:0], (sig_r[24] ? sig_r[23:1] : sig_r[22:0])};
        end
    end

endmodule

// File: rtl/fp_mul_rr_pick.sv
// Round-robin winner search: first valid bit at or above ptr, wrapping at NUM_REQ.
module fp_mul_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         in_valid,
    input  logic [$clog2(NUM_REQ)-1:0] in_ptr,
    output logic [NUM_REQ-1:0]         out_grant,
    output logic [$clog2(NUM_REQ)-1:0] out_idx,
    output logic                       out_any
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] cand;

    always_comb begin
        out_grant = '0;
        out_idx   = '0;
        out_any   = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(in_ptr) + k) % NUM_REQ);
            if (!out_any && in_valid[cand]) begin
                out_any         = 1'b1;
                out_grant[cand] = 1'b1;
                out_idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP_Mul between NUM_REQ requesters: grant, settle one cycle, return tagged product.
// Optional completed-operation counter enabled by FP_MUL_ARB_STATS_EN.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    fp_mul_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr, win_idx, id_q;
    logic [NUM_REQ-1:0]  win_grant, req_ready;
    logic                any_valid, load_op, cap_res, rsp_valid;
    logic [FP_WIDTH-1:0] op_a, op_b, mul_res, res_q;

    fp_mul_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .in_valid  (bus.in_req_valid),
        .in_ptr    (rr_ptr),
        .out_grant (win_grant),
        .out_idx   (win_idx),
        .out_any   (any_valid)
    );

    FP_Mul u_mul (
        .in_numA    (op_a),
        .in_numB    (op_b),
        .out_result (mul_res)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        load_op   = 1'b0;
        cap_res   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready = win_grant;
                    load_op   = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cap_res = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (bus.in_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_op) begin
                op_a   <= bus.in_req_numA[win_idx*FP_WIDTH +: FP_WIDTH];
                op_b   <= bus.in_req_numB[win_idx*FP_WIDTH +: FP_WIDTH];
                id_q   <= win_idx;
                rr_ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (cap_res) begin
                res_q <= mul_res;
            end
        end
    end

    assign bus.out_req_ready  = req_ready;
    assign bus.out_rsp_valid  = rsp_valid;
    assign bus.out_rsp_id     = id_q;
    assign bus.out_rsp_result = res_q;

`ifdef FP_MUL_ARB_STATS_EN
    logic [OP_COUNT_W-1:0] op_count;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && bus.in_rsp_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign bus.out_op_count = op_count;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed and randomized checks of fp_mul_arbiter against a transaction-level reference.
module tb_fp_mul_arbiter;

    localparam int unsigned N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_mul_arbiter_if #(.NUM_REQ(N)) bus ();

    fp_mul_arbiter #(.NUM_REQ(N)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact single-precision encoding of a signed integer below 2^24.
    function automatic logic [31:0] i2f(input logic sgn, input int unsigned n);
        int unsigned p;
        logic [31:0] m;
        if (n == 0) return {sgn, 31'd0};
        p = 0;
        for (int i = 0; i < 32; i++) if (n[i]) p = i;
        m = 32'(n << (23 - p));
        return {sgn, 8'(127 + p), m[22:0]};
    endfunction

    // Reference arbitration rule: first valid requester at or after the pointer, cyclically.
    function automatic int unsigned model_pick(input logic [N-1:0] v, input int unsigned p);
        for (int unsigned k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return N;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, ":ready"}, 32'(bus.out_req_ready), 32'd0);
        check({tag, ":rspv"},  32'(bus.out_rsp_valid), 32'd0);
        check({tag, ":id"},    32'(bus.out_rsp_id), 32'd0);
        check({tag, ":res"},   bus.out_rsp_result, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_req_valid = '0;
        bus.in_rsp_ready = 1'b0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction: grant this cycle, response two cycles later, bp stalled cycles.
    task automatic do_op(input string tag, input logic [N-1:0] vld,
                         input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                         input int unsigned exp_w, input logic [31:0] exp_res,
                         input int unsigned bp);
        @(negedge clk);
        bus.in_req_valid = vld;
        bus.in_req_numA  = a;
        bus.in_req_numB  = b;
        bus.in_rsp_ready = 1'b0;
        #1;
        check({tag, ":grant"}, 32'(bus.out_req_ready), 32'(1) << exp_w);
        check({tag, ":rspv_idle"}, 32'(bus.out_rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, ":ready_busy"}, 32'(bus.out_req_ready), 32'd0);
        check({tag, ":rspv_busy"}, 32'(bus.out_rsp_valid), 32'd0);
        @(negedge clk);
        for (int unsigned i = 0; i < bp; i++) begin
            #1;
            check({tag, ":rspv_hold"}, 32'(bus.out_rsp_valid), 32'd1);
            check({tag, ":id_hold"}, 32'(bus.out_rsp_id), exp_w);
            check({tag, ":res_hold"}, bus.out_rsp_result, exp_res);
            check({tag, ":ready_hold"}, 32'(bus.out_req_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_rsp_ready = 1'b1;
        #1;
        check({tag, ":rspv"}, 32'(bus.out_rsp_valid), 32'd1);
        check({tag, ":id"}, 32'(bus.out_rsp_id), exp_w);
        check({tag, ":res"}, bus.out_rsp_result, exp_res);
        check({tag, ":ready_done"}, 32'(bus.out_req_ready), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "time limit");
    end

    initial begin
        logic [N*32-1:0] va, vb;
        logic [31:0]     e;
        int unsigned     mptr, w;
        logic [N-1:0]    v;
        int unsigned     ai [N];
        int unsigned     bi [N];
        logic            sa [N];
        logic            sb [N];

        bus.in_req_valid = '0;
        bus.in_req_numA  = '0;
        bus.in_req_numB  = '0;
        bus.in_rsp_ready = 1'b0;

        do_reset();

        // single request from requester 0: 1.0 * 2.0
        va = '0; vb = '0;
        va[31:0] = 32'h3F80_0000;
        vb[31:0] = 32'h4000_0000;
        do_op("single", 4'b0001, va, vb, 0, 32'h4000_0000, 0);

        // round-robin from a fresh pointer, all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            va[i*32 +: 32] = i2f(1'b0, i + 1);
            vb[i*32 +: 32] = i2f(1'b0, i + 2);
        end
        do_op("rr0", 4'b1111, va, vb, 0, i2f(1'b0, 2), 0);
        do_op("rr1", 4'b1111, va, vb, 1, i2f(1'b0, 6), 0);
        do_op("rr2", 4'b1111, va, vb, 2, i2f(1'b0, 12), 0);
        do_op("rr3", 4'b1111, va, vb, 3, i2f(1'b0, 20), 0);
        do_op("rr4", 4'b1111, va, vb, 0, i2f(1'b0, 2), 0);

        // pointer wrap: last grant to 3, then 1 and 2 contend
        do_op("wrap3", 4'b1000, va, vb, 3, i2f(1'b0, 20), 0);
        do_op("wrap1", 4'b0110, va, vb, 1, i2f(1'b0, 6), 0);
        do_op("wrap2", 4'b0110, va, vb, 2, i2f(1'b0, 12), 0);

        // backpressure: 3.0 * 4.0 held for 10 cycles while all requesters wait
        for (int i = 0; i < N; i++) begin
            va[i*32 +: 32] = 32'h4040_0000;
            vb[i*32 +: 32] = 32'h4080_0000;
        end
        do_op("bp", 4'b1111, va, vb, 3, 32'h4140_0000, 10);

        // reset while BUSY discards the product and restarts the pointer at 0
        @(negedge clk);
        bus.in_rsp_ready = 1'b0;
        bus.in_req_valid = 4'b0010;
        #1;
        check("rstbusy:grant", 32'(bus.out_req_ready), 32'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_req_valid = '0;
        #1;
        check_outputs_zero("rstbusy");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rstbusy:no_rsp", 32'(bus.out_rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("rstbusy:no_rsp2", 32'(bus.out_rsp_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
            va[i*32 +: 32] = i2f(1'b0, i + 3);
            vb[i*32 +: 32] = i2f(1'b1, 5);
        end
        do_op("rstbusy:after", 4'b0101, va, vb, 0, i2f(1'b1, 15), 0);

        // randomized traffic against the reference rule
        do_reset();
        mptr = 0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.in_req_valid = '0;
                bus.in_rsp_ready = 1'b0;
                #1;
                check("rand:idle_ready", 32'(bus.out_req_ready), 32'd0);
                check("rand:idle_rspv", 32'(bus.out_rsp_valid), 32'd0);
            end
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                ai[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4095);
                bi[i] = $urandom_range(1, 4095);
                sa[i] = 1'($urandom_range(0, 1));
                sb[i] = 1'($urandom_range(0, 1));
                va[i*32 +: 32] = i2f(sa[i], ai[i]);
                vb[i*32 +: 32] = i2f(sb[i], bi[i]);
            end
            w    = model_pick(v, mptr);
            e    = i2f(sa[w] ^ sb[w], ai[w] * bi[w]);
            mptr = (w + 1) % N;
            do_op("rand", v, va, vb, w, e, $urandom_range(0, 3));
        end

`ifdef FP_MUL_ARB_STATS_EN
        do_reset();
        check("stats:reset", 32'(bus.out_op_count), 32'd0);
        for (int i = 0; i < N; i++) begin
            va[i*32 +: 32] = 32'h4000_0000;
            vb[i*32 +: 32] = 32'h4000_0000;
        end
        do_op("stats:first", 4'b0001, va, vb, 0, 32'h4080_0000, 0);
        @(negedge clk);
        bus.in_req_valid = '0;
        bus.in_rsp_ready = 1'b0;
        #1;
        check("stats:one", 32'(bus.out_op_count), 32'd1);
        mptr = 0;
        for (int i = 1; i < 65536; i++) begin
            mptr = (mptr + 1) % N;
            do_op("stats", 4'b1111, va, vb, mptr, 32'h4080_0000, 0);
        end
        @(negedge clk);
        bus.in_req_valid = '0;
        bus.in_rsp_ready = 1'b0;
        #1;
        check("stats:wrap", 32'(bus.out_op_count), 32'd0);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
